// File: rtl/fetch_seq_ctrl.sv
// Next-PC sequencer and fetch controller with a one-entry skid buffer.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_VEC.
module fetch_seq_ctrl #(
  parameter logic [31:0] BOOT_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter logic [3:0]  MAX_WAIT = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_sel,
  output logic [31:0] pc_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap,
  output logic        fetch_err,
  output logic [2:0]  state_o
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_STALL = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        req_n, vld_n, err_n;
  logic        kill, kill_n;
  logic [3:0]  wait_cnt, cnt_n;
  logic [31:0] addr_n, out_n, ipc_n;
  logic [31:0] skid_data, skd_n;
  logic [31:0] skid_pc, skpc_n;
  logic [31:0] br_addr;
  logic        do_br, redirect, slot_free;

  assign state_o = state;

`ifdef MISALIGN_TRAP_EN
  logic misal;
  assign misal      = br_target[1:0] != 2'b00;
  assign br_addr    = misal ? TRAP_VEC : br_target;
  assign misalign_o = do_br && !trap && misal;
`else
  assign br_addr = br_target & ~32'd3;
`endif

  // Branches are meaningless before boot and after a fetch error.
  assign do_br     = br_taken && (state != S_BOOT) && (state != S_HALT);
  assign redirect  = trap || do_br;
  assign slot_free = !instr_valid || id_ready;

  always_comb begin
    state_n = state;
    req_n   = imem_req;
    addr_n  = imem_addr;
    vld_n   = instr_valid && !id_ready;
    out_n   = instr_out;
    ipc_n   = instr_pc;
    err_n   = fetch_err;
    kill_n  = kill;
    cnt_n   = wait_cnt;
    skd_n   = skid_data;
    skpc_n  = skid_pc;
    pc_sel  = 1'b1;
    pc_addr = pc_in;
    if (redirect) begin
      pc_addr = trap ? TRAP_VEC : br_addr;
      vld_n   = 1'b0;
      skd_n   = '0;
      skpc_n  = '0;
      if (state == S_WAIT && !imem_ack) begin
        // Request stays up; its late data is dropped via kill.
        kill_n = 1'b1;
        if (wait_cnt != MAX_WAIT) cnt_n = wait_cnt + 4'd1;
      end else begin
        state_n = S_FETCH;
        req_n   = 1'b0;
        kill_n  = 1'b0;
        if (state == S_HALT) err_n = 1'b0;
      end
    end else begin
      unique case (state)
        S_BOOT: begin
          pc_addr = BOOT_VEC;
          state_n = S_FETCH;
        end
        S_FETCH: begin
          addr_n  = pc_in;
          req_n   = 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_ack) begin
            req_n   = 1'b0;
            state_n = S_FETCH;
            if (kill) begin
              kill_n = 1'b0;
            end else if (slot_free) begin
              out_n  = imem_rdata;
              ipc_n  = imem_addr;
              vld_n  = 1'b1;
              pc_sel = 1'b0;
            end else begin
              skd_n   = imem_rdata;
              skpc_n  = imem_addr;
              state_n = S_STALL;
            end
          end else if (wait_cnt == MAX_WAIT) begin
            err_n   = 1'b1;
            req_n   = 1'b0;
            state_n = S_HALT;
          end else begin
            cnt_n = wait_cnt + 4'd1;
          end
        end
        S_STALL: begin
          if (id_ready) begin
            out_n   = skid_data;
            ipc_n   = skid_pc;
            vld_n   = 1'b1;
            pc_sel  = 1'b0;
            state_n = S_FETCH;
          end
        end
        S_HALT: begin
          state_n = S_HALT;
        end
        default: state_n = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_BOOT;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
      kill        <= 1'b0;
      wait_cnt    <= '0;
      skid_data   <= '0;
      skid_pc     <= '0;
    end else begin
      state       <= state_n;
      imem_req    <= req_n;
      imem_addr   <= addr_n;
      instr_valid <= vld_n;
      instr_out   <= out_n;
      instr_pc    <= ipc_n;
      fetch_err   <= err_n;
      kill        <= kill_n;
      wait_cnt    <= cnt_n;
      skid_data   <= skd_n;
      skid_pc     <= skpc_n;
    end
  end

endmodule
